// File: rtl/r_pkt_fifo.sv
// rtl/r_pkt_fifo.sv - per-destination router packet FIFO
// Flag-tagged byte storage with packet tracking, read-side strobes and sticky errors.
module r_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LEN_MSB    = 7,
  parameter int LEN_LSB    = 2,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    soft_reset,
  input  logic                    write_enb,
  input  logic                    sof_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read_enb,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    dout_valid,
  output logic                    dout_sof,
  output logic                    dout_eop,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  pkt_count,
  output logic                    overflow_err,
  output logic                    orphan_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = LEN_MSB - LEN_LSB + 1;
  localparam int RW = LW + 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  logic [DATA_WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [RW-1:0]        rem;
  logic [DATA_WIDTH:0]  rd_word;
  logic                 rd_flag;
  logic [LW-1:0]        rd_len;
  logic                 do_wr;
  logic                 do_rd;
  logic                 pkt_inc;
  logic                 pkt_dec;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // Full/empty come from pre-edge pointers, so a read never frees room for a same-cycle write.
  assign do_wr = write_enb && !full;
  assign do_rd = read_enb && !empty;

  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign rd_flag = rd_word[DATA_WIDTH];
  assign rd_len  = rd_word[LEN_MSB:LEN_LSB];

  assign pkt_inc = do_wr && sof_in;
  assign pkt_dec = do_rd && rd_flag;

  always_ff @(posedge clk) begin
    if (!reset && !soft_reset && do_wr) begin
      mem[wr_ptr[AW-1:0]] <= {sof_in, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pkt_count    <= '0;
      rem          <= '0;
      data_out     <= '0;
      dout_valid   <= 1'b0;
      dout_sof     <= 1'b0;
      dout_eop     <= 1'b0;
      overflow_err <= 1'b0;
      orphan_err   <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_count  <= '0;
      rem        <= '0;
      data_out   <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eop   <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (write_enb && full) begin
        overflow_err <= 1'b1;
      end

      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_count <= pkt_count + PW'(1);
        2'b01:   pkt_count <= pkt_count - PW'(1);
        default: pkt_count <= pkt_count;
      endcase

      dout_valid <= do_rd;
      dout_sof   <= 1'b0;
      dout_eop   <= 1'b0;
      if (do_rd) begin
        rd_ptr   <= rd_ptr + PW'(1);
        data_out <= rd_word[DATA_WIDTH-1:0];
        if (rd_flag) begin
          // A header always restarts the count, even if the previous packet was cut short.
          rem      <= RW'(rd_len) + RW'(1);
          dout_sof <= 1'b1;
        end else if (rem != '0) begin
          rem      <= rem - RW'(1);
          dout_eop <= (rem == RW'(1));
        end else begin
          orphan_err <= 1'b1;
        end
      end
    end
  end

endmodule
